// File: rtl/div_unit.sv
// Iterative restoring divider for the execute stage: signed/unsigned divide and modulo,
// valid/ready on operands and result, with a flush that cancels the in-flight operation.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_divzero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             accept;
    logic             in_signed;
    logic             in_divzero;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    logic             op_unsigned_q;
    logic             op_mod_q;
    logic             dvd_neg_q;
    logic             dvs_neg_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign in_ready   = (state == S_IDLE) && !flush;
    assign accept     = in_valid && in_ready;
    assign in_signed  = !in_op[1];
    assign in_divzero = (in_divisor == '0);

    assign abs_dividend = (in_signed && in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
    assign abs_divisor  = (in_signed && in_divisor[WIDTH-1])  ? -in_divisor  : in_divisor;

    // dq_q holds the remaining dividend bits in its top and collects quotient bits at its bottom
    assign shifted   = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
    assign trial     = {rem_q, dq_q[WIDTH-1]} - {2'b00, dvs_q};
    assign trial_neg = trial[WIDTH+1];

    assign quot_fix = (!op_unsigned_q && (dvd_neg_q ^ dvs_neg_q)) ? -dq_q : dq_q;
    assign rem_fix  = (!op_unsigned_q && dvd_neg_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; flush overrides everything
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = in_divzero ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == LAST_ITER) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Operand latch and one restoring iteration per CALC cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_unsigned_q <= 1'b0;
            op_mod_q      <= 1'b0;
            dvd_neg_q     <= 1'b0;
            dvs_neg_q     <= 1'b0;
            dq_q          <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
        end else if (accept) begin
            op_unsigned_q <= in_op[1];
            op_mod_q      <= in_op[0];
            dvd_neg_q     <= in_signed && in_dividend[WIDTH-1];
            dvs_neg_q     <= in_signed && in_divisor[WIDTH-1];
            dq_q          <= abs_dividend;
            dvs_q         <= abs_divisor;
            rem_q         <= '0;
            cnt_q         <= '0;
        end else if (state == S_CALC) begin
            rem_q <= trial_neg ? shifted : trial[WIDTH:0];
            dq_q  <= {dq_q[WIDTH-2:0], !trial_neg};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers; out_result only changes when a new result is produced
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_divzero <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && in_divzero) begin
            out_valid   <= 1'b1;
            out_divzero <= 1'b1;
            out_result  <= in_op[0] ? in_dividend : '1;
        end else if (state == S_FIX) begin
            out_valid   <= 1'b1;
            out_divzero <= 1'b0;
            out_result  <= op_mod_q ? rem_fix : quot_fix;
        end else if ((state == S_DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: 32-bit and 8-bit instances, hand-computed quotient/remainder,
// latency, backpressure, flush and mid-operation reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic        in_valid32 = 1'b0;
    logic        in_valid8 = 1'b0;

    logic        in_ready32, out_valid32, out_divzero32;
    logic [31:0] out_result32;
    logic        in_ready8, out_valid8, out_divzero8;
    logic [7:0]  out_result8;

    logic        use8 = 1'b0;
    logic        ir, ov, dz;
    logic [31:0] res;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_result(out_result32), .out_divzero(out_divzero32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op),
        .in_dividend(in_dividend[7:0]), .in_divisor(in_divisor[7:0]), .flush(flush),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_result(out_result8), .out_divzero(out_divzero8)
    );

    assign ir  = use8 ? in_ready8 : in_ready32;
    assign ov  = use8 ? out_valid8 : out_valid32;
    assign dz  = use8 ? out_divzero8 : out_divzero32;
    assign res = use8 ? {24'h0, out_result8} : out_result32;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operation, let it be accepted, then scramble the operand inputs
    task automatic accept_only(input string tag, input bit w8, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        use8 = w8;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(ir), 32'd1);
        in_op = op;
        in_dividend = a;
        in_divisor = b;
        if (w8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        in_valid32 = 1'b0;
        in_op = ~op;
        in_dividend = ~a;
        in_divisor = 32'h3;
    endtask

    task automatic issue(input string tag, input bit w8, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        accept_only(tag, w8, op, a, b);
        lat = 1;
        while (!ov && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input bit w8, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit exp_dz, input int exp_lat);
        int lat;
        issue(tag, w8, op, a, b, lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_result"}, res, exp);
        check_eq({tag, "_divzero"}, 32'(dz), 32'(exp_dz));
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_ready_after"}, 32'(ir), 32'd1);
        check_eq({tag, "_valid_after"}, 32'(ov), 32'd0);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov) seen++;
        end
        check_eq({tag, "_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid32), 32'd0);
        check_eq("rst_result", out_result32, 32'd0);
        check_eq("rst_divzero", 32'(out_divzero32), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready32), 32'd1);

        do_op("udiv",    1'b0, 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        do_op("umod",    1'b0, 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 34);
        do_op("udiv_max",1'b0, 2'b10, 32'hFFFFFFFF, 32'd10, 32'h19999999, 1'b0, 34);
        do_op("umod_max",1'b0, 2'b11, 32'hFFFFFFFF, 32'd10, 32'd5, 1'b0, 34);
        do_op("sdiv_neg",1'b0, 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 34);
        do_op("smod_neg",1'b0, 2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 34);
        do_op("smod_nd", 1'b0, 2'b01, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 34);
        do_op("sdiv_nd", 1'b0, 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34);
        do_op("sdiv_ovf",1'b0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34);
        do_op("smod_ovf",1'b0, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
        do_op("sdiv_z",  1'b0, 2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1);
        do_op("umod_z",  1'b0, 2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 1);
        do_op("smod_z",  1'b0, 2'b01, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, 1);
        do_op("udiv_nz", 1'b0, 2'b10, 32'd9, 32'd3, 32'd3, 1'b0, 34);

        // Backpressure: result held, no new accept until taken
        out_ready = 1'b0;
        issue("bp", 1'b0, 2'b10, 32'd100, 32'd7, lat);
        check_eq("bp_latency", 32'(lat), 32'd34);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_result", res, 32'd14);
            check_eq("bp_valid", 32'(ov), 32'd1);
            check_eq("bp_in_ready", 32'(ir), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_ready_after", 32'(ir), 32'd1);
        check_eq("bp_valid_after", 32'(ov), 32'd0);

        // Flush in CALC cycle 10
        accept_only("fl", 1'b0, 2'b10, 32'd1000, 32'd10);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check_eq("fl_in_ready_low", 32'(ir), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("fl_in_ready", 32'(ir), 32'd1);
        check_eq("fl_valid", 32'(ov), 32'd0);
        watch_idle("fl", 40);
        do_op("fl_next", 1'b0, 2'b10, 32'd1000, 32'd10, 32'd100, 1'b0, 34);

        // Reset in CALC cycle 5
        accept_only("rs", 1'b0, 2'b10, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        check_eq("rs_valid", 32'(ov), 32'd0);
        check_eq("rs_result", res, 32'd0);
        check_eq("rs_divzero", 32'(dz), 32'd0);
        check_eq("rs_in_ready", 32'(ir), 32'd1);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        watch_idle("rs", 40);
        do_op("rs_next", 1'b0, 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 34);

        // 8-bit instance
        do_op("w8_ovf",  1'b1, 2'b00, 32'h80, 32'hFF, 32'h80, 1'b0, 10);
        do_op("w8_udiv", 1'b1, 2'b10, 32'h64, 32'h07, 32'h0E, 1'b0, 10);
        do_op("w8_umod", 1'b1, 2'b11, 32'h64, 32'h07, 32'h02, 1'b0, 10);
        do_op("w8_smod", 1'b1, 2'b01, 32'hF9, 32'h02, 32'hFF, 1'b0, 10);
        do_op("w8_sdivz",1'b1, 2'b00, 32'h05, 32'h00, 32'hFF, 1'b1, 1);
        do_op("w8_sdiv", 1'b1, 2'b00, 32'hF9, 32'h02, 32'hFD, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
